// File: rtl/conv_14_mul_share_arb_if.sv
// Requester-side request/response bundle for the shared multiplier arbiter.
// The arbiter takes the slave modport; requesters (or a bench) take the master modport.
interface conv_14_mul_share_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 16,
   parameter int B_W     = 8,
   parameter int P_W     = A_W + B_W
) ();
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;
   logic [P_W-1:0]         rsp_p;
   logic                   idle;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_p, idle
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_p, idle
   );
endinterface

// File: rtl/conv_14_mul_share_arb.sv
// Round-robin share of one signed A_W x B_W multiplier; MUL_STAGES cycles accept->rsp_valid.
// A full output slot whose owner is not ready freezes the whole pipeline and blocks new grants.
module conv_14_mul_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int A_W        = 16,
   parameter int B_W        = 8,
   parameter int P_W        = A_W + B_W,
   parameter int MUL_STAGES = 2,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic                    ap_clk,
   input logic                    ap_rst_n,
   conv_14_mul_share_arb_if.slave bus
);
   localparam int LAST = MUL_STAGES - 1;

   logic [MUL_STAGES-1:0] stg_vld;
   logic [ID_W-1:0]       stg_tag  [MUL_STAGES];
   logic [P_W-1:0]        stg_prod [MUL_STAGES];

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  gnt_id;
   logic [ID_W-1:0]  idx;
   logic             gnt_found;
   logic             out_valid;
   logic [ID_W-1:0]  out_id;
   logic             adv;
   logic             accept;
   logic [A_W-1:0]   a_sel;
   logic [B_W-1:0]   b_sel;
   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;
   logic signed [P_W-1:0] mul_res;

   // First requesting index at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!gnt_found && bus.req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   assign out_valid = stg_vld[LAST];
   assign out_id    = stg_tag[LAST];
   assign adv       = ~out_valid | bus.rsp_ready[out_id];
   assign accept    = gnt_found & adv & ap_rst_n;

   assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;
   assign bus.rsp_valid = out_valid ? (NUM_REQ'(1) << out_id) : '0;
   assign bus.rsp_p     = stg_prod[LAST];
   assign bus.idle      = ~|stg_vld;

   assign a_sel   = bus.req_a[int'(gnt_id)*A_W +: A_W];
   assign b_sel   = bus.req_b[int'(gnt_id)*B_W +: B_W];
   assign a_ext   = P_W'($signed(a_sel));
   assign b_ext   = P_W'($signed(b_sel));
   assign mul_res = a_ext * b_ext;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rr_ptr  <= '0;
         stg_vld <= '0;
         for (int s = 0; s < MUL_STAGES; s++) begin
            stg_tag[s]  <= '0;
            stg_prod[s] <= '0;
         end
      end else begin
         if (accept) begin
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         end
         // Bubbles travel with the data; nothing moves unless the output slot can drain.
         if (adv) begin
            stg_vld[0]  <= accept;
            stg_tag[0]  <= gnt_id;
            stg_prod[0] <= mul_res;
            for (int s = 1; s < MUL_STAGES; s++) begin
               stg_vld[s]  <= stg_vld[s-1];
               stg_tag[s]  <= stg_tag[s-1];
               stg_prod[s] <= stg_prod[s-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_14_mul_share_arb.sv
// Bench for conv_14_mul_share_arb: vector table plus arbitration/scoreboard monitor and corner sequences.
module tb_conv_14_mul_share_arb;
   logic ap_clk;
   logic ap_rst_n;

   conv_14_mul_share_arb_if #(.NUM_REQ(4), .A_W(16), .B_W(8), .P_W(24)) bus ();

   conv_14_mul_share_arb #(.NUM_REQ(4), .A_W(16), .B_W(8), .P_W(24), .MUL_STAGES(2)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [23:0] p;
   } vec_t;

   typedef struct {
      logic [1:0]  id;
      logic [23:0] p;
   } sb_t;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   mptr   = 0;
   int   rsp_cnt = 0;
   sb_t  sbq[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] mul_model(logic [15:0] a, logic [7:0] b);
      int sa, sb, p;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = sa * sb;
      return p[23:0];
   endfunction

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge ap_clk);
      #1;
   endtask

   task automatic set_op(int r, logic [15:0] a, logic [7:0] b);
      bus.req_a[r*16 +: 16] = a;
      bus.req_b[r*8 +: 8]   = b;
   endtask

   // Arbitration model and in-order product scoreboard, sampled mid-cycle.
   always @(negedge ap_clk) begin
      logic       adv_o;
      logic [3:0] exp_rdy;
      logic       found;
      int         id;
      sb_t        e;
      if (!ap_rst_n) begin
         sbq.delete();
         mptr = 0;
      end else begin
         adv_o   = (bus.rsp_valid == 4'b0) || ((bus.rsp_valid & bus.rsp_ready) != 4'b0);
         exp_rdy = 4'b0;
         found   = 1'b0;
         if (adv_o) begin
            for (int k = 0; k < 4; k++) begin
               if (!found && bus.req_valid[(mptr + k) % 4]) begin
                  found   = 1'b1;
                  exp_rdy = 4'(1 << ((mptr + k) % 4));
               end
            end
         end
         if (bus.req_valid != 4'b0) chk("arb_grant", 32'(bus.req_ready), 32'(exp_rdy));
         if ((bus.req_valid & bus.req_ready) != 4'b0) begin
            id = 0;
            for (int k = 0; k < 4; k++) if (bus.req_ready[k]) id = k;
            e.id = 2'(id);
            e.p  = mul_model(bus.req_a[id*16 +: 16], bus.req_b[id*8 +: 8]);
            sbq.push_back(e);
            mptr = (id + 1) % 4;
         end
         if ((bus.rsp_valid & bus.rsp_ready) != 4'b0) begin
            rsp_cnt++;
            id = 0;
            for (int k = 0; k < 4; k++) if (bus.rsp_valid[k]) id = k;
            if (sbq.size() == 0) begin
               chk("sb_unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
            end else begin
               e = sbq.pop_front();
               chk("sb_rsp_id", 32'(id), 32'(e.id));
               chk("sb_rsp_p", 32'(bus.rsp_p), 32'(e.p));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   task automatic single_op(int r, logic [15:0] a, logic [7:0] b, logic [23:0] exp_p);
      set_op(r, a, b);
      bus.req_valid = 4'(1 << r);
      mid();
      chk("op_accept", 32'(bus.req_ready), 32'(1 << r));
      tick();
      bus.req_valid = 4'b0;
      mid();
      chk("op_lat_early", 32'(bus.rsp_valid), 32'h0);
      chk("op_busy", 32'(bus.idle), 32'h0);
      tick();
      mid();
      chk("op_rsp_valid", 32'(bus.rsp_valid), 32'(1 << r));
      chk("op_rsp_p", 32'(bus.rsp_p), 32'(exp_p));
      tick();
      mid();
      chk("op_idle", 32'(bus.idle), 32'h1);
      tick();
   endtask

   initial begin
      vec_t        vt[8];
      logic [15:0] sa[6];
      logic [7:0]  sbv[6];
      int          acc;
      int          base;

      vt[0] = '{16'h7FFF, 8'h7F, 24'h3F7F81};
      vt[1] = '{16'h8000, 8'h80, 24'h400000};
      vt[2] = '{16'h8000, 8'h7F, 24'hC08000};
      vt[3] = '{16'hFFFF, 8'h01, 24'hFFFFFF};
      vt[4] = '{16'h0000, 8'h80, 24'h000000};
      vt[5] = '{16'h0003, 8'hFE, 24'hFFFFFA};
      vt[6] = '{16'h1234, 8'h10, 24'h012340};
      vt[7] = '{16'h7FFF, 8'h80, 24'hC00080};

      ap_rst_n      = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 4'b1111;

      // Reset state
      tick();
      mid();
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_p", 32'(bus.rsp_p), 32'h0);
      chk("rst_idle", 32'(bus.idle), 32'h1);
      tick();
      bus.req_valid = 4'b0;
      ap_rst_n      = 1'b1;
      tick();

      // Fairness: all four requesting, one grant per cycle, responses lag by two.
      for (int i = 0; i < 4; i++) set_op(i, 16'(100 * (i + 1) - 250), 8'(i * 40 - 70));
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) bus.req_valid = 4'b0;
         mid();
         if (k < 8) chk("fair_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
         if (k >= 2) chk("fair_rsp", 32'(bus.rsp_valid), 32'(1 << ((k - 2) % 4)));
         tick();
      end
      mid();
      chk("fair_idle", 32'(bus.idle), 32'h1);
      tick();

      // Vector table, rotating over requesters.
      for (int v = 0; v < 8; v++) begin
         chk("table_model", 32'(mul_model(vt[v].a, vt[v].b)), 32'(vt[v].p));
         single_op(v % 4, vt[v].a, vt[v].b, vt[v].p);
      end

      // Pointer wrap: leave rr_ptr at 1, then 0101 must alternate 2,0,2.
      single_op(0, 16'h0005, 8'h03, 24'h00000F);
      set_op(2, 16'h0102, 8'h05);
      bus.req_valid = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("wrap_grant", 32'(bus.req_ready), (k == 1) ? 32'h1 : 32'h4);
         tick();
      end
      bus.req_valid = 4'b0;
      for (int k = 0; k < 3; k++) tick();

      // Backpressure: stream six ops from requester 3, stall three cycles once the output fills.
      for (int k = 0; k < 6; k++) begin
         sa[k]  = 16'(k * 1237 - 3000);
         sbv[k] = 8'(k * 17 - 50);
      end
      acc  = 0;
      base = rsp_cnt;
      for (int cyc = 0; cyc < 16; cyc++) begin
         bus.req_valid = (acc < 6) ? 4'b1000 : 4'b0000;
         if (acc < 6) set_op(3, sa[acc], sbv[acc]);
         bus.rsp_ready = (cyc >= 2 && cyc <= 4) ? 4'b0111 : 4'b1111;
         mid();
         if (cyc >= 2 && cyc <= 4) begin
            chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'h8);
            chk("stall_rsp_p", 32'(bus.rsp_p), 32'(mul_model(sa[0], sbv[0])));
         end
         if (bus.req_ready[3]) acc++;
         tick();
      end
      bus.req_valid = 4'b0;
      bus.rsp_ready = 4'b1111;
      chk("stall_rsp_count", 32'(rsp_cnt - base), 32'd6);
      chk("stall_sb_empty", 32'(sbq.size()), 32'h0);

      // Reset with two operations in flight.
      set_op(0, 16'h0011, 8'h22);
      set_op(1, 16'h0033, 8'h44);
      bus.req_valid = 4'b0011;
      bus.rsp_ready = 4'b0000;
      tick();
      tick();
      chk("rst_pre_rsp", 32'(bus.rsp_valid), 32'h1);
      ap_rst_n = 1'b0;
      #1;
      chk("rst_now_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_now_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_now_idle", 32'(bus.idle), 32'h1);
      tick();
      tick();
      bus.req_valid = 4'b0;
      bus.rsp_ready = 4'b1111;
      ap_rst_n      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mid();
         chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
         tick();
      end
      set_op(3, 16'hFFFE, 8'h03);
      bus.req_valid = 4'b1010;
      mid();
      chk("post_rst_grant", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 4'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("final_sb_empty", 32'(sbq.size()), 32'h0);
      chk("final_idle", 32'(bus.idle), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
